// File: rtl/jk_pkg.sv
// Shared op codes and FSM state encoding for the JK bank sequencer.
package jk_pkg;

  // Ops are encoded as {j,k}, so the bits drive the cell pins directly.
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage flop with asynchronous active-low clear.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        OP_CLR:  q <= 1'b0;
        OP_SET:  q <= 1'b1;
        OP_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Round-robin sequencer feeding JK commands from two requesters into a bank
// of N_BITS JK cells; toggles may repeat for cnt+1 cycles.
module jk_bank_sequencer
  import jk_pkg::*;
#(
  parameter  int N_BITS = 8,
  parameter  int CNT_W  = 4,
  localparam int IDX_W  = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [IDX_W-1:0]  req0_idx,
  input  logic [1:0]        req0_op,
  input  logic [CNT_W-1:0]  req0_cnt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [IDX_W-1:0]  req1_idx,
  input  logic [1:0]        req1_op,
  input  logic [CNT_W-1:0]  req1_cnt,
  output logic [N_BITS-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state_q;
  logic               last_grant_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, err_q;
  logic               grant, accept, in_range, last_exec;
  logic [N_BITS-1:0]  j_vec, k_vec;

  // grant=1 selects requester 1; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready | req1_ready;

  assign idx_d = grant ? req1_idx : req0_idx;
  assign op_d  = grant ? req1_op  : req0_op;
  assign cnt_d = grant ? req1_cnt : req0_cnt;

  assign in_range  = {1'b0, idx_q} < (IDX_W+1)'(N_BITS);
  assign last_exec = (op_q != OP_TGL) || (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= '0;
      op_q         <= OP_HOLD;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q      <= ST_EXEC;
            last_grant_q <= grant;
            idx_q        <= idx_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
          end
        end
        ST_EXEC: begin
          if (last_exec) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= !in_range;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range indices match no cell, so such commands leave q untouched.
  for (genvar g = 0; g < N_BITS; g++) begin : g_cell
    logic sel;
    assign sel      = (state_q == ST_EXEC) && (idx_q == IDX_W'(g));
    assign j_vec[g] = sel & op_q[1];
    assign k_vec[g] = sel & op_q[0];

    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_vec[g]),
      .k     (k_vec[g]),
      .q     (q[g])
    );
  end

  assign busy = (state_q == ST_EXEC);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer; a 6-cell bank lets a 3-bit index
// address the out-of-range cells 6 and 7.
module tb_jk_bank_sequencer;

  localparam int N_BITS = 6;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = $clog2(N_BITS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [IDX_W-1:0]  req0_idx, req1_idx;
  logic [1:0]        req0_op, req1_op;
  logic [CNT_W-1:0]  req0_cnt, req1_cnt;
  logic [N_BITS-1:0] q;
  logic              busy, done, err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_bank_sequencer #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_idx   (req0_idx),
    .req0_op    (req0_op),
    .req0_cnt   (req0_cnt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_idx   (req1_idx),
    .req1_op    (req1_op),
    .req1_cnt   (req1_cnt),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_idx = '0; req0_op = 2'b00; req0_cnt = '0;
    req1_valid = 1'b0; req1_idx = '0; req1_op = 2'b00; req1_cnt = '0;
    tick(); tick();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single set: idx3
    req0_valid = 1; req0_idx = 3; req0_op = 2'b10; req0_cnt = 0;
    #1;
    chk("set_rdy0", req0_ready, 1);
    chk("set_rdy1", req1_ready, 0);
    tick(); req0_valid = 0;
    chk("set_busy", busy, 1);
    chk("set_q_early", q, 6'h00);
    tick();
    chk("set_q", q, 6'h08);
    chk("set_done", done, 1);
    chk("set_busy_off", busy, 0);
    tick();
    chk("set_done_off", done, 0);

    // Repeated toggle on idx5, cnt=3 -> four toggles
    req1_valid = 1; req1_idx = 5; req1_op = 2'b11; req1_cnt = 3;
    #1;
    chk("tgl_rdy1", req1_ready, 1);
    tick(); req1_valid = 0;
    chk("tgl_busy", busy, 1);
    tick(); chk("tgl_q1", q, 6'h28);
    tick(); chk("tgl_q2", q, 6'h08);
    tick(); chk("tgl_q3", q, 6'h28);
    chk("tgl_busy3", busy, 1);
    chk("tgl_done3", done, 0);
    tick(); chk("tgl_q4", q, 6'h08);
    chk("tgl_done", done, 1);
    chk("tgl_busy_off", busy, 0);
    tick();

    // Contention: grants must alternate 0,1,0,1
    req0_valid = 1; req0_idx = 0; req0_op = 2'b10;
    req1_valid = 1; req1_idx = 1; req1_op = 2'b10; req1_cnt = 0;
    #1;
    chk("rr_g0_rdy0", req0_ready, 1);
    chk("rr_g0_rdy1", req1_ready, 0);
    tick(); req0_op = 2'b01;
    #1;
    chk("rr_exec_rdy0", req0_ready, 0);
    chk("rr_exec_rdy1", req1_ready, 0);
    tick(); #1;
    chk("rr_g1_rdy1", req1_ready, 1);
    chk("rr_g1_rdy0", req0_ready, 0);
    chk("rr_q_a", q, 6'h09);
    tick(); req1_op = 2'b01;
    tick(); #1;
    chk("rr_g2_rdy0", req0_ready, 1);
    chk("rr_g2_rdy1", req1_ready, 0);
    chk("rr_q_b", q, 6'h0B);
    tick(); req0_valid = 0;
    tick(); #1;
    chk("rr_g3_rdy1", req1_ready, 1);
    chk("rr_g3_rdy0", req0_ready, 0);
    chk("rr_q_c", q, 6'h0A);
    tick(); req1_valid = 0;
    tick();
    chk("rr_q_d", q, 6'h08);
    chk("rr_done", done, 1);
    tick();

    // Out-of-range index 7
    req0_valid = 1; req0_idx = 7; req0_op = 2'b01; req0_cnt = 0;
    #1;
    chk("oor_rdy0", req0_ready, 1);
    tick(); req0_valid = 0;
    chk("oor_busy", busy, 1);
    tick();
    chk("oor_done", done, 1);
    chk("oor_err", err, 1);
    chk("oor_q", q, 6'h08);
    tick();
    chk("oor_err_off", err, 0);
    chk("oor_done_off", done, 0);

    // Long toggle aborted by reset in the 5th EXEC cycle
    req0_valid = 1; req0_idx = 2; req0_op = 2'b11; req0_cnt = 15;
    #1;
    chk("abt_rdy0", req0_ready, 1);
    tick(); req0_valid = 0;
    tick(); chk("abt_q1", q, 6'h0C);
    tick(); chk("abt_q2", q, 6'h08);
    tick(); chk("abt_q3", q, 6'h0C);
    tick();
    chk("abt_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abt_q_rst", q, 6'h00);
    chk("abt_busy_rst", busy, 0);
    chk("abt_done_rst", done, 0);
    tick();
    chk("abt_done_hold", done, 0);
    rst_n = 1'b1;
    tick();
    chk("abt_busy_rel", busy, 0);
    req1_valid = 1; req1_idx = 0; req1_op = 2'b10; req1_cnt = 0;
    #1;
    chk("abt_rdy1", req1_ready, 1);
    tick(); req1_valid = 0;
    tick();
    chk("abt_post_q", q, 6'h01);
    chk("abt_post_done", done, 1);
    tick();
    chk("abt_post_busy", busy, 0);
    chk("abt_post_q2", q, 6'h01);

    // Set / hold / clear on idx4, each with its own done
    req0_valid = 1; req0_idx = 4; req0_op = 2'b10; req0_cnt = 0;
    #1;
    chk("shc_rdy_set", req0_ready, 1);
    tick(); req0_valid = 0;
    tick();
    chk("shc_q_set", q, 6'h11);
    chk("shc_done_set", done, 1);
    req0_valid = 1; req0_op = 2'b00;
    #1;
    chk("shc_rdy_hold", req0_ready, 1);
    tick(); req0_valid = 0;
    chk("shc_busy_hold", busy, 1);
    chk("shc_done_gap", done, 0);
    tick();
    chk("shc_q_hold", q, 6'h11);
    chk("shc_done_hold", done, 1);
    req0_valid = 1; req0_op = 2'b01;
    #1;
    chk("shc_rdy_clr", req0_ready, 1);
    tick(); req0_valid = 0;
    tick();
    chk("shc_q_clr", q, 6'h01);
    chk("shc_done_clr", done, 1);
    tick();
    chk("shc_done_off", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
